// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined word selector.
// Every tree level travels as one packed bundle {tag, err, data, residual sel}.
// The helpers below give the width and bit offset of each level in that layout.
package mux_pkg;

   localparam int TAG_W = 8;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v * 2;
         r++;
      end
      return r;
   endfunction

   function automatic int ipow(input int base, input int exp_n);
      int r;
      r = 1;
      for (int i = 0; i < exp_n; i++) r = r * base;
      return r;
   endfunction

   function automatic int stages_for(input int num_in, input int radix);
      int s;
      int span;
      s = 0;
      span = 1;
      while (span < num_in) begin
         span = span * radix;
         s++;
      end
      return s;
   endfunction

   // Bundle width at tree level lvl (level 0 = padded leaves, level stages = result).
   function automatic int level_w(input int lvl, input int stages, input int radix,
                                  input int width);
      return clog2(radix) * (stages - lvl) + ipow(radix, stages - lvl) * width + 1 + TAG_W;
   endfunction

   function automatic int level_off(input int lvl, input int stages, input int radix,
                                    input int width);
      int off;
      off = 0;
      for (int j = 0; j < lvl; j++) off = off + level_w(j, stages, radix, width);
      return off;
   endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Request/result handshake bundle for mux_pipe_n.
// The master drives requests and accepts results; the slave is the selector.
interface mux_pipe_n_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 32
);
   import mux_pkg::*;

   localparam int SEL_W = clog2(NUM_IN);

   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [TAG_W-1:0]        out_tag;
   logic                    out_err;

   modport master (
      output in_valid, in_sel, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_sel, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_err
   );

endinterface

// File: rtl/mux_radix_stage.sv
// One registered level of the select tree: every group of RADIX candidates is
// reduced to one word with the low sel digit, and the remaining sel bits, tag
// and err ride along. The register reloads whenever it is empty or its content
// is taken downstream, so bubbles collapse and stalls propagate upstream.
module mux_radix_stage
   import mux_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NODES    = 1,
   parameter int RADIX    = 4,
   parameter int SEL_IN_W = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic in_valid,
   output logic in_ready,
   input  logic [TAG_W+1+NODES*RADIX*WIDTH+SEL_IN_W-1:0] in_bus,
   output logic out_valid,
   input  logic out_ready,
   output logic [TAG_W+1+NODES*WIDTH+SEL_IN_W-clog2(RADIX)-1:0] out_bus
);

   localparam int LOG_R     = clog2(RADIX);
   localparam int SEL_OUT_W = SEL_IN_W - LOG_R;
   localparam int CAND_W    = NODES * RADIX * WIDTH;
   localparam int DATA_W    = NODES * WIDTH;
   localparam int IN_W      = TAG_W + 1 + CAND_W + SEL_IN_W;
   localparam int OUT_W     = TAG_W + 1 + DATA_W + SEL_OUT_W;

   logic [SEL_IN_W-1:0] sel;
   logic [CAND_W-1:0]   cand;
   logic                err;
   logic [TAG_W-1:0]    tag;
   logic [LOG_R-1:0]    digit;
   logic [DATA_W-1:0]   picked;
   logic [OUT_W-1:0]    nxt;
   logic [OUT_W-1:0]    bus_q;
   logic                valid_q;
   logic                load;

   assign sel   = in_bus[SEL_IN_W-1:0];
   assign cand  = in_bus[SEL_IN_W +: CAND_W];
   assign err   = in_bus[SEL_IN_W + CAND_W];
   assign tag   = in_bus[IN_W-1 -: TAG_W];
   assign digit = sel[LOG_R-1:0];

   // All groups at this level use the same digit, so one index per node.
   always_comb begin
      picked = '0;
      for (int n = 0; n < NODES; n++) begin
         picked[n*WIDTH +: WIDTH] = cand[(n*RADIX + int'(digit))*WIDTH +: WIDTH];
      end
   end

   // Residual sel sits in the low bits; on the last level it has no width left.
   assign nxt = (OUT_W'({tag, err, picked}) << SEL_OUT_W) | OUT_W'(sel >> LOG_R);

   assign load     = !valid_q || out_ready;
   assign in_ready = load;

   // Stage register: hold while stalled, refill (or bubble) when it drains.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         bus_q   <= '0;
      end else begin
         if (load) valid_q <= in_valid;
         if (load && in_valid) bus_q <= nxt;
      end
   end

   assign out_valid = valid_q;
   assign out_bus   = bus_q;

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined NUM_IN-to-1 word selector with a register after every radix-RADIX
// tree level and valid/ready flow control. Selects beyond NUM_IN land on the
// zero padding leaves, so they return zero data and are flagged on out_err.
module mux_pipe_n
   import mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 32,
   parameter int RADIX  = 4
) (
   input  logic          clock,
   input  logic          reset,
   mux_pipe_n_if.slave   bus
);

   localparam int STAGES = stages_for(NUM_IN, RADIX);
   localparam int LOG_R  = clog2(RADIX);
   localparam int LEAVES = ipow(RADIX, STAGES);
   localparam int LEAF_W = LEAVES * WIDTH;
   localparam int SELP_W = STAGES * LOG_R;
   localparam int W0     = level_w(0, STAGES, RADIX, WIDTH);
   localparam int OFF_L  = level_off(STAGES, STAGES, RADIX, WIDTH);
   localparam int TREE_W = level_off(STAGES + 1, STAGES, RADIX, WIDTH);

   logic [TREE_W-1:0] tree;
   logic              vld [0:STAGES];
   logic              rdy [0:STAGES];
   logic              in_err;

   assign in_err = (32'(bus.in_sel) >= 32'(NUM_IN));

   // Leaf level: raw words zero-extended to a full RADIX^STAGES tree.
   assign tree[W0-1:0] = {bus.in_tag, in_err, LEAF_W'(bus.in_data), SELP_W'(bus.in_sel)};
   assign vld[0]       = bus.in_valid;
   assign bus.in_ready = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int OFF_I = level_off(k, STAGES, RADIX, WIDTH);
      localparam int W_I   = level_w(k, STAGES, RADIX, WIDTH);
      localparam int OFF_O = level_off(k + 1, STAGES, RADIX, WIDTH);
      localparam int W_O   = level_w(k + 1, STAGES, RADIX, WIDTH);

      mux_radix_stage #(
         .WIDTH    (WIDTH),
         .NODES    (ipow(RADIX, STAGES - k - 1)),
         .RADIX    (RADIX),
         .SEL_IN_W (LOG_R * (STAGES - k))
      ) u_stage (
         .clock     (clock),
         .reset     (reset),
         .in_valid  (vld[k]),
         .in_ready  (rdy[k]),
         .in_bus    (tree[OFF_I +: W_I]),
         .out_valid (vld[k+1]),
         .out_ready (rdy[k+1]),
         .out_bus   (tree[OFF_O +: W_O])
      );
   end

   assign rdy[STAGES]   = bus.out_ready;
   assign bus.out_valid = vld[STAGES];
   assign bus.out_data  = tree[OFF_L +: WIDTH];
   assign bus.out_err   = tree[OFF_L + WIDTH];
   assign bus.out_tag   = tree[OFF_L + WIDTH + 1 +: TAG_W];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three configurations (32x32 radix 4, 5 words radix 2,
// 1-bit 2 words radix 2) checked against an in-order queue of expected results.
module tb_mux_pipe_n;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  tag;
      logic        err;
      int          acc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_acc = 0;
   logic [7:0] tag_ctr = 8'd0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mux_pipe_n_if #(.WIDTH(32), .NUM_IN(32)) ifa ();
   mux_pipe_n_if #(.WIDTH(32), .NUM_IN(5))  ifb ();
   mux_pipe_n_if #(.WIDTH(1),  .NUM_IN(2))  ifc ();

   mux_pipe_n #(.WIDTH(32), .NUM_IN(32), .RADIX(4)) dut_a (
      .clock (clock), .reset (reset), .bus (ifa.slave));
   mux_pipe_n #(.WIDTH(32), .NUM_IN(5),  .RADIX(2)) dut_b (
      .clock (clock), .reset (reset), .bus (ifb.slave));
   mux_pipe_n #(.WIDTH(1),  .NUM_IN(2),  .RADIX(2)) dut_c (
      .clock (clock), .reset (reset), .bus (ifc.slave));

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One cycle on the 32-word DUT; outputs are sampled 2 time units after the edge.
   task automatic step_a(input bit v, input int sel, input bit rdy, input bit lat_chk,
                         input bit rand_data);
      exp_t e;
      @(posedge clock);
      #1;
      if (rand_data)
         for (int i = 0; i < 32; i++) ifa.in_data[i*32 +: 32] = $urandom();
      ifa.in_valid  = v;
      ifa.in_sel    = 5'(sel);
      ifa.in_tag    = tag_ctr;
      ifa.out_ready = rdy;
      #1;
      check_eq("a_in_ready", 64'(ifa.in_ready), 64'((qa.size() < 3) || rdy));
      if (qa.size() == 0) begin
         check_eq("a_idle_valid", 64'(ifa.out_valid), 64'(0));
      end else if (ifa.out_valid) begin
         check_eq("a_data", 64'(ifa.out_data), 64'(qa[0].data));
         check_eq("a_tag",  64'(ifa.out_tag),  64'(qa[0].tag));
         check_eq("a_err",  64'(ifa.out_err),  64'(qa[0].err));
         if (rdy) begin
            if (lat_chk) check_eq("a_latency", 64'(cyc - qa[0].acc), 64'(3));
            void'(qa.pop_front());
         end
      end
      if (v && ifa.in_ready) begin
         e.data = ifa.in_data[sel*32 +: 32];
         e.tag  = tag_ctr;
         e.err  = 1'b0;
         e.acc  = cyc;
         qa.push_back(e);
         tag_ctr++;
         n_acc++;
      end
   endtask

   // 5-word DUT, out_ready held high: results must appear exactly 3 cycles later.
   task automatic step_b(input bit v, input int sel);
      exp_t e;
      bit   due;
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) ifb.in_data[i*32 +: 32] = $urandom();
      ifb.in_valid  = v;
      ifb.in_sel    = 3'(sel);
      ifb.in_tag    = tag_ctr;
      ifb.out_ready = 1'b1;
      #1;
      check_eq("b_in_ready", 64'(ifb.in_ready), 64'(1));
      due = 1'b0;
      if (qb.size() > 0) due = (cyc - qb[0].acc == 3);
      check_eq("b_out_valid", 64'(ifb.out_valid), 64'(due));
      if (ifb.out_valid && qb.size() > 0) begin
         e = qb.pop_front();
         check_eq("b_data", 64'(ifb.out_data), 64'(e.data));
         check_eq("b_tag",  64'(ifb.out_tag),  64'(e.tag));
         check_eq("b_err",  64'(ifb.out_err),  64'(e.err));
      end
      if (v && ifb.in_ready) begin
         if (sel < 5) e.data = ifb.in_data[sel*32 +: 32];
         else         e.data = 32'd0;
         e.err = (sel >= 5);
         e.tag = tag_ctr;
         e.acc = cyc;
         qb.push_back(e);
         tag_ctr++;
      end
   endtask

   // 1-bit, 2-word DUT: single stage, one cycle of latency.
   task automatic step_c(input bit v, input int sel);
      exp_t e;
      bit   due;
      @(posedge clock);
      #1;
      ifc.in_data   = 2'($urandom_range(0, 3));
      ifc.in_valid  = v;
      ifc.in_sel    = 1'(sel);
      ifc.in_tag    = tag_ctr;
      ifc.out_ready = 1'b1;
      #1;
      due = 1'b0;
      if (qc.size() > 0) due = (cyc - qc[0].acc == 1);
      check_eq("c_out_valid", 64'(ifc.out_valid), 64'(due));
      if (ifc.out_valid && qc.size() > 0) begin
         e = qc.pop_front();
         check_eq("c_data", 64'(ifc.out_data), 64'(e.data));
         check_eq("c_tag",  64'(ifc.out_tag),  64'(e.tag));
         check_eq("c_err",  64'(ifc.out_err),  64'(e.err));
      end
      if (v && ifc.in_ready) begin
         e.data = {31'd0, ifc.in_data[sel]};
         e.err  = 1'b0;
         e.tag  = tag_ctr;
         e.acc  = cyc;
         qc.push_back(e);
         tag_ctr++;
      end
   endtask

   task automatic check_a_reset_outputs(input string pfx);
      check_eq({pfx, "_out_valid"}, 64'(ifa.out_valid), 64'(0));
      check_eq({pfx, "_out_data"},  64'(ifa.out_data),  64'(0));
      check_eq({pfx, "_out_tag"},   64'(ifa.out_tag),   64'(0));
      check_eq({pfx, "_out_err"},   64'(ifa.out_err),   64'(0));
      check_eq({pfx, "_in_ready"},  64'(ifa.in_ready),  64'(1));
   endtask

   initial begin
      int b_sels [8];
      int c_sels [6];
      int base_acc;
      int guard;

      ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.in_data = '0; ifa.in_tag = '0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.in_data = '0; ifb.in_tag = '0; ifb.out_ready = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_sel = '0; ifc.in_data = '0; ifc.in_tag = '0; ifc.out_ready = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check_a_reset_outputs("por");
      reset = 1'b0;

      // Back-to-back selects 0..31 on a fixed word pattern.
      for (int i = 0; i < 32; i++) ifa.in_data[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
      for (int s = 0; s < 32; s++) step_a(1'b1, s, 1'b1, 1'b1, 1'b0);
      repeat (5) step_a(1'b0, 0, 1'b1, 1'b1, 1'b0);
      check_eq("a_seq_drained", 64'(qa.size()), 64'(0));

      // Fill with the consumer stalled, hold, then push and pop together.
      base_acc = n_acc;
      repeat (5) step_a(1'b1, int'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1);
      check_eq("a_fill_count", 64'(n_acc - base_acc), 64'(3));
      repeat (3) step_a(1'b0, 0, 1'b0, 1'b0, 1'b0);
      base_acc = n_acc;
      repeat (4) step_a(1'b1, int'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b1);
      check_eq("a_pushpop_count", 64'(n_acc - base_acc), 64'(4));
      repeat (6) step_a(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check_eq("a_fill_drained", 64'(qa.size()), 64'(0));

      // Random valid/ready at 50% each.
      n_acc = 0;
      guard = 0;
      while (n_acc < 10000 && guard < 60000) begin
         step_a(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'b0, 1'b1);
         guard++;
      end
      check_eq("a_rand_accepted", 64'(n_acc), 64'(10000));
      repeat (8) step_a(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check_eq("a_rand_drained", 64'(qa.size()), 64'(0));

      // Reset with two requests in flight.
      step_a(1'b1, 5, 1'b1, 1'b0, 1'b1);
      step_a(1'b1, 9, 1'b1, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      ifa.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_a_reset_outputs("mid_rst");
      qa.delete();
      repeat (2) @(posedge clock);
      #1;
      check_a_reset_outputs("mid_rst_hold");
      reset = 1'b0;
      step_a(1'b0, 0, 1'b0, 1'b0, 1'b0);
      step_a(1'b1, 17, 1'b1, 1'b1, 1'b1);
      repeat (4) step_a(1'b0, 0, 1'b1, 1'b1, 1'b0);
      check_eq("a_post_rst_drained", 64'(qa.size()), 64'(0));

      // Five words, radix 2: out-of-range selects flagged and zeroed.
      b_sels = '{7, 4, 0, 5, 6, 3, 1, 2};
      foreach (b_sels[i]) step_b(1'b1, b_sels[i]);
      step_b(1'b0, 0);
      step_b(1'b1, 7);
      repeat (5) step_b(1'b0, 0);
      check_eq("b_drained", 64'(qb.size()), 64'(0));

      // One-bit words, single stage.
      c_sels = '{0, 1, 1, 0, 1, 0};
      foreach (c_sels[i]) step_c(1'b1, c_sels[i]);
      step_c(1'b0, 0);
      step_c(1'b1, 1);
      repeat (3) step_c(1'b0, 0);
      check_eq("c_drained", 64'(qc.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised, pipelined N-to-1 word selector: the successor to the fixed 32-way, 32-bit combinational mux tree. It selects one of NUM_IN words of WIDTH bits, registering after every radix-RADIX tree level, with a valid/ready handshake and stall propagation. Used in the miner datapath wherever a wide word select (message-schedule word, nonce-lane result) must close timing at the hashing-core clock. Out-of-range selects are flagged rather than silently aliased.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- NUM_IN, 32, number of input words (2..256)
- RADIX, 4, inputs per tree node (2, 4 or 8)
- STAGES, derived = ceil(log_RADIX(NUM_IN)), pipeline depth; not overridable
- SEL_W, derived = ceil(log2(NUM_IN)), select width

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- in_valid  in  1  request present this cycle
- in_ready  out  1  block accepts request this cycle
- in_sel  in  SEL_W  index of the word to select
- in_data  in  NUM_IN*WIDTH  flattened words, word i at bits [i*WIDTH +: WIDTH]
- in_tag  in  8  opaque sideband, carried with the request
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  selected word
- out_tag  out  8  tag of this result
- out_err  out  1  request had in_sel ≥ NUM_IN

## Operation
- Request accepted on a clock edge where in_valid && in_ready.
- Stage k (k = 0..STAGES-1) reduces groups of RADIX candidates to one using sel digit k (the least-significant log2(RADIX) bits first); the remaining sel bits, tag, err and valid travel with the data.
- Missing leaves (index ≥ NUM_IN in the last, partial group) read as zero.
- in_sel ≥ NUM_IN: out_data = 0, out_err = 1, still produces exactly one result with its tag.
- Stall rule: each stage register loads when it is empty or its downstream consumer takes its content (bubble collapsing). in_ready = stage-0 load condition. Pipeline holds data, tag and err stable while out_valid && !out_ready.
- Order preserved; no reordering, no drops, no duplicates.
- Reset (any time, including mid-stream): all valid bits 0, out_data 0, out_tag 0, out_err 0, in_ready 1 from the first edge after reset deasserts. In-flight requests are discarded.

## Timing
- Latency: exactly STAGES cycles from acceptance to out_valid with out_ready held high (defaults: STAGES = 3).
- Throughput: one result per cycle when out_ready is held high.
- in_ready is combinational from out_ready and stage valids only, never from in_valid.
- Capacity: STAGES requests in flight. When full and out_ready = 0, in_ready = 0.
- Simultaneous pop and push on a full pipe: both succeed in the same cycle.
- in_data need be stable only in the acceptance cycle. Stage 0 registers only the RADIX^(STAGES-1) group results, not raw in_data.

## Structure
- Package mux_pkg: clog2 function, stages_for(num_in, radix) function, TAG_W = 8 constant.
- Sub-module mux_radix_stage (parameters WIDTH, NODES, RADIX): one registered tree level holding data, residual sel, tag, err, valid, and its local load/stall logic. Top level instantiates STAGES copies in a generate loop, plus padding and range-check logic.

## Test plan
- Defaults, in_data word i = 0xA5A50000+i, sel 0..31 back-to-back, out_ready = 1 → out_data = 0xA5A50000+sel on each cycle starting 3 cycles after first acceptance, tags in order, out_err = 0.
- NUM_IN = 5, RADIX = 2 (STAGES 3), sel = 7 → out_data 0, out_err 1. sel = 4 → word 4, out_err 0.
- Fill the pipe with out_ready = 0 → in_ready drops after 3 acceptances. Results stay stable while stalled. out_ready = 1 with in_valid = 1 → push and pop in the same cycle, no loss.
- Random in_valid/out_ready at 50% each, 10k requests → scoreboard matches in order, zero drops or duplicates.
- Assert reset with 2 requests in flight → out_valid 0, all outputs 0 during reset. The first new request after reset emerges after 3 cycles with the correct value.
- WIDTH = 1, NUM_IN = 2, RADIX = 2 (STAGES 1) → latency 1 cycle, sel 0/1 selects bit 0/1.
